fv_stim_seq: RTL

FV_STIM_SEQ -- requirements
Module: fv_stim_seq

---
 rtl/fv_stim_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fv_stim_seq.sv
// Stimulus sequencer: offers LEN vectors (MULTI/SEL) downstream, then pulses DONE, or ABORT on a stall timeout.
// Latency: VALID rises one cycle after START is sampled in IDLE. Every output is registered.
// Backpressure: READY low holds MULTI/SEL/CNT. STALL_MAX consecutive stalled cycles abort the run.
//
// Ports:
//   CLK, RST        rising-edge clock; asynchronous active-high reset
//   START, LEN      begin a run of LEN vectors (LEN 0 means 16)
//   READY           downstream accepts the offered vector
//   VALID           MULTI/SEL hold a vector on offer
//   MULTI           3-bit stimulus vector
//   SEL             parity of the accepted-vector count
//   BUSY            not IDLE
//   DONE            one-cycle pulse when a run completes
//   ABORT           one-cycle pulse on a stall timeout
//   CNT             vectors accepted in the current or last run
// Build option: define FV_STIM_LFSR_EN to step MULTI as a 3-bit LFSR.
//   When the macro is undefined, MULTI steps as a binary up-counter.

module fv_stim_seq #(
    parameter logic [2:0] SEED      = 3'b001,
    parameter int         STALL_MAX = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] LEN,
    input  logic       READY,
    output logic       VALID,
    output logic [2:0] MULTI,
    output logic       SEL,
    output logic       BUSY,
    output logic       DONE,
    output logic       ABORT,
    output logic [4:0] CNT
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN,
        ERR
    } state_t;

    localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

    state_t     state;
    logic [3:0] stall_cnt;
    logic [4:0] len_q;

    logic [2:0] seed_eff;
    logic [2:0] multi_next;
    logic [4:0] cnt_inc;
    logic [3:0] stall_inc;

`ifdef FV_STIM_LFSR_EN
    // An all-zero seed would lock the LFSR, so it is forced to 3'b001.
    // The feedback is m[2]^m[0]. This gives the full 7-state cycle 1,3,7,6,5,2,4.
    assign seed_eff   = (SEED == 3'b000) ? 3'b001 : SEED;
    assign multi_next = {MULTI[1:0], MULTI[2] ^ MULTI[0]};
`else
    assign seed_eff   = SEED;
    assign multi_next = MULTI + 3'd1;
`endif

    assign cnt_inc   = CNT + 5'd1;
    assign stall_inc = stall_cnt + 4'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            VALID     <= 1'b0;
            MULTI     <= 3'b000;
            SEL       <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ABORT     <= 1'b0;
            CNT       <= 5'd0;
            stall_cnt <= 4'd0;
            len_q     <= 5'd16;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state     <= RUN;
                        VALID     <= 1'b1;
                        BUSY      <= 1'b1;
                        len_q     <= (LEN == 4'd0) ? 5'd16 : {1'b0, LEN};
                        MULTI     <= seed_eff;
                        SEL       <= 1'b0;
                        CNT       <= 5'd0;
                        stall_cnt <= 4'd0;
                    end
                end
                RUN: begin
                    // VALID is always 1 in RUN, so READY alone marks an acceptance.
                    if (READY) begin
                        CNT       <= cnt_inc;
                        SEL       <= ~SEL;
                        MULTI     <= multi_next;
                        stall_cnt <= 4'd0;
                        // An acceptance clears the stall count.
                        // So a completion takes priority over a timeout in the same cycle.
                        if (cnt_inc == len_q) begin
                            state <= FIN;
                            VALID <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        stall_cnt <= stall_inc;
                        if (stall_inc == STALL_LIM) begin
                            state <= ERR;
                            VALID <= 1'b0;
                            ABORT <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
                ERR: begin
                    // CNT keeps the partial count for inspection.
                    state <= IDLE;
                    ABORT <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    ABORT <= 1'b0;
                end
            endcase
        end
    end

endmodule
